// File: rtl/piso_serializer_pkg.sv
// Shared types and helpers for the PISO serializer.
// State encoding and counter-width function.
package piso_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((int'(1) << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/piso_serializer_bit_counter.sv
// Width-generic bit counter: clear, enable, terminal-count flag.
// Ports: clk_i, rst_i, clr_i, en_i in; tc_o high at count Width-1.
module piso_bit_counter
  import piso_serializer_pkg::*;
#(
  parameter int Width = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CntW = clog2(Width);
  localparam logic [CntW-1:0] Last = CntW'(Width - 1);

  logic [CntW-1:0] cnt_q;

  // Saturates at Last so it never wraps inside a word.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !tc_o) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  assign tc_o = (cnt_q == Last);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer, valid/ready load, tick-paced shift.
// Ports: clk_i, rst_i, d_i, valid_i, lsb_first_i, tick_i, abort_i in;
//        ready_o, q_o, q_valid_o, busy_o, done_o out.
// Optional even-parity trailer bit: define PISO_SERIALIZER_PARITY_EN.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int Width     = 8,
  parameter bit IdleLevel = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             lsb_first_i,
  input  logic             tick_i,
  input  logic             abort_i,
  output logic             q_o,
  output logic             q_valid_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e state_q, state_d;

  logic [Width-1:0] sreg_q;
  logic lsb_q;
  logic done_q, done_d;
  logic tc;
  logic accept;
  logic busy;
  logic shift_en;
  logic last_tick;
  logic cnt_clr;

`ifdef PISO_SERIALIZER_PARITY_EN
  logic par_q;
`endif

  assign busy      = (state_q != ST_IDLE);
  assign accept    = valid_i && (state_q == ST_IDLE);
  assign shift_en  = (state_q == ST_SHIFT) && tick_i && !abort_i;
  assign last_tick = shift_en && tc;
  assign cnt_clr   = accept || (busy && abort_i) || last_tick;

  piso_bit_counter #(
    .Width(Width)
  ) u_cnt (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .clr_i(cnt_clr),
    .en_i (shift_en),
    .tc_o (tc)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (valid_i) state_d = ST_SHIFT;
      end
      (state_q == ST_SHIFT): begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (tick_i && tc) begin
`ifdef PISO_SERIALIZER_PARITY_EN
          state_d = ST_PARITY;
`else
          state_d = ST_IDLE;
          done_d  = 1'b1;
`endif
        end
      end
`ifdef PISO_SERIALIZER_PARITY_EN
      (state_q == ST_PARITY): begin
        if (abort_i) begin
          state_d = ST_IDLE;
        end else if (tick_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // Zero fill means the register is already clear after the last shift.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sreg_q <= '0;
      lsb_q  <= 1'b0;
    end else if (accept) begin
      sreg_q <= d_i;
      lsb_q  <= lsb_first_i;
    end else if (busy && abort_i) begin
      sreg_q <= '0;
    end else if (shift_en) begin
      if (lsb_q) sreg_q <= sreg_q >> 1;
      else       sreg_q <= sreg_q << 1;
    end
  end

`ifdef PISO_SERIALIZER_PARITY_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= ^d_i;
    end
  end
`endif

  always_comb begin
    q_o = IdleLevel;
    unique case (1'b1)
      (state_q == ST_SHIFT):
        q_o = lsb_q ? sreg_q[0] : sreg_q[Width-1];
`ifdef PISO_SERIALIZER_PARITY_EN
      (state_q == ST_PARITY):
        q_o = par_q;
`endif
      default: q_o = IdleLevel;
    endcase
  end

  assign ready_o   = !busy;
  assign busy_o    = busy;
  assign q_valid_o = busy;
  assign done_o    = done_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed self-checking bench for piso_serializer (Width=8, idle 0).
// Honours PISO_SERIALIZER_PARITY_EN for the trailing parity bit.
module tb_piso_serializer;

`ifdef PISO_SERIALIZER_PARITY_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] d = 8'h00;
  logic       valid = 1'b0;
  logic       ready;
  logic       lsb = 1'b0;
  logic       tick = 1'b0;
  logic       abort = 1'b0;
  logic       q;
  logic       qv;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  piso_serializer #(
    .Width    (8),
    .IdleLevel(1'b0)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .d_i        (d),
    .valid_i    (valid),
    .ready_o    (ready),
    .lsb_first_i(lsb),
    .tick_i     (tick),
    .abort_i    (abort),
    .q_o        (q),
    .q_valid_o  (qv),
    .busy_o     (busy),
    .done_o     (done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic seen;
    rst = 1'b1;
    step();
    step();
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || q !== 1'b0 ||
        qv !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: rdy=%b busy=%b q=%b qv=%b done=%b want 1 0 0 0 0",
               ready, busy, q, qv, done);
    end
    rst = 1'b0;
    d = 8'hFF; valid = 1'b1; tick = 1'b1;
    step();
    valid = 1'b0;
    step(); step(); step();
    checks++;
    if (busy !== 1'b1 || q !== 1'b1) begin
      errors++;
      $display("FAIL reset_midword_pre: busy=%b q=%b want 1 1", busy, q);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tick = 1'b0;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || q !== 1'b0 || qv !== 1'b0) begin
      errors++;
      $display("FAIL reset_midword: rdy=%b busy=%b q=%b qv=%b want 1 0 0 0",
               ready, busy, q, qv);
    end
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done !== 1'b0) seen = 1'b1;
      tick = 1'b1;
      step();
    end
    tick = 1'b0;
    checks++;
    if (seen !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: done_seen=%b busy=%b want 0 0", seen, busy);
    end
  endtask

  task automatic test_msb_first();
    logic [0:8] e;
    e = 9'b100101100;
    d = 8'h96; lsb = 1'b0; valid = 1'b1; tick = 1'b1;
    step();
    valid = 1'b0;
    lsb = 1'b1;
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (q !== e[i] || qv !== 1'b1 || done !== 1'b0 || ready !== 1'b0) begin
        errors++;
        $display("FAIL msb_bit%0d: q=%b qv=%b done=%b rdy=%b want q=%b 1 0 0",
                 i, q, qv, done, ready, e[i]);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || ready !== 1'b1 || q !== 1'b0 || qv !== 1'b0) begin
      errors++;
      $display("FAIL msb_done: done=%b rdy=%b q=%b qv=%b want 1 1 0 0",
               done, ready, q, qv);
    end
    step();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL msb_done_width: done=%b want 0", done);
    end
    tick = 1'b0;
    lsb = 1'b0;
  endtask

  task automatic test_lsb_first();
    logic [0:8] e;
    logic       ok;
    e = 9'b011010010;
    d = 8'h96; lsb = 1'b1; valid = 1'b1; tick = 1'b0;
    step();
    valid = 1'b0;
    lsb = 1'b0;
    checks++;
    if (q !== 1'b0 || qv !== 1'b1) begin
      errors++;
      $display("FAIL lsb_first_bit_no_tick: q=%b qv=%b want 0 1", q, qv);
    end
    for (int i = 0; i < NB; i++) begin
      ok = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (q !== e[i] || qv !== 1'b1 || done !== 1'b0) ok = 1'b0;
        tick = (c == 3);
        step();
      end
      tick = 1'b0;
      checks++;
      if (ok !== 1'b1) begin
        errors++;
        $display("FAIL lsb_bit%0d: not held at %b for 4 cycles (last q=%b)",
                 i, e[i], q);
      end
    end
    checks++;
    if (done !== 1'b1 || ready !== 1'b1) begin
      errors++;
      $display("FAIL lsb_done: done=%b rdy=%b want 1 1", done, ready);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [0:8] e1;
    logic [0:8] e2;
    e1 = 9'b000000011;
    e2 = 9'b111111110;
    d = 8'h01; lsb = 1'b0; valid = 1'b1; tick = 1'b1;
    step();
    d = 8'hFF;
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (q !== e1[i] || ready !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL b2b_w1_bit%0d: q=%b rdy=%b busy=%b want %b 0 1",
                 i, q, ready, busy, e1[i]);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: done=%b rdy=%b busy=%b want 1 1 0",
               done, ready, busy);
    end
    step();
    valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (q !== e2[i] || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL b2b_w2_bit%0d: q=%b busy=%b done=%b want %b 1 0",
                 i, q, busy, done, e2[i]);
      end
      step();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_w2_done: done=%b want 1", done);
    end
    tick = 1'b0;
    step();
  endtask

  task automatic test_abort();
    logic [0:8] e;
    logic       ok;
    e = 9'b101000000;
    d = 8'h5A; lsb = 1'b0; valid = 1'b1; tick = 1'b1;
    step();
    valid = 1'b0;
    for (int i = 0; i < 5; i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    tick = 1'b0;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || q !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: rdy=%b busy=%b done=%b q=%b want 1 0 0 0",
               ready, busy, done, q);
    end
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (done !== 1'b0) ok = 1'b0;
      step();
    end
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("FAIL abort_no_done: done pulsed, want none");
    end
    d = 8'hA0; valid = 1'b1; abort = 1'b1; tick = 1'b1;
    step();
    valid = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (q !== e[i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL abort_next_bit%0d: q=%b busy=%b want %b 1",
                 i, q, busy, e[i]);
      end
      step();
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL abort_next_done: done=%b want 1", done);
    end
    tick = 1'b0;
    step();
  endtask

  task automatic test_parity();
    logic [0:8] e;
    e = 9'b000001111;
    d = 8'h07; lsb = 1'b0; valid = 1'b1; tick = 1'b1;
    step();
    valid = 1'b0;
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (q !== e[i] || qv !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL parity_bit%0d: q=%b qv=%b done=%b want %b 1 0",
                 i, q, qv, done, e[i]);
      end
      step();
    end
    checks++;
    if (done !== 1'b1 || ready !== 1'b1) begin
      errors++;
      $display("FAIL parity_done: done=%b rdy=%b want 1 1", done, ready);
    end
    tick = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_msb_first();
    test_lsb_first();
    test_back_to_back();
    test_abort();
    test_parity();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parametrised parallel-in/serial-out serializer with a valid/ready load handshake, a shift-enable strobe, and selectable bit order.
- Accepts a Width-bit word, emits it one bit per accepted tick_i, then signals completion.
- Sits between a parallel data source (e.g. a FIFO) and a serial line driver (UART/SPI-style TX datapath).

Parameters:
- Width, 8, data word width in bits; legal range 2..64.
- IdleLevel, 0, value driven on q_o when no word is being shifted (1'b0 or 1'b1).

Ports:
- clk_i  input  1  system clock, rising edge.
- rst_i  input  1  synchronous, active-high reset.
- d_i  input  Width  parallel word to serialize.
- valid_i  input  1  d_i is valid; word is accepted when valid_i && ready_o at a rising edge.
- ready_o  output  1  block can accept a word (high only in IDLE).
- lsb_first_i  input  1  bit order, sampled with the word: 1 = LSB first, 0 = MSB first.
- tick_i  input  1  shift-enable strobe; the current bit advances on an edge where tick_i=1.
- abort_i  input  1  cancels the word in flight.
- q_o  output  1  serial data out.
- q_valid_o  output  1  q_o carries a data (or parity) bit.
- busy_o  output  1  a word is in flight.
- done_o  output  1  one-cycle pulse after the last bit completes.

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high on rst_i; it has priority over every other input, including mid-word.
- Reset values: state=IDLE, shift register=0, bit counter=0, q_o=IdleLevel, q_valid_o=0, busy_o=0, done_o=0, ready_o=1.
- States are IDLE, SHIFT and PARITY (PARITY exists only with the optional feature).
- IDLE:
  - ready_o=1, q_o=IdleLevel, q_valid_o=0.
  - On valid_i && ready_o: load d_i, latch lsb_first_i, clear the counter, go to SHIFT.
  - valid_i while not in IDLE is ignored; the source must hold the word until accepted.
- SHIFT:
  - busy_o=1, q_valid_o=1.
  - q_o = MSB (or LSB) of the shift register, presented combinationally from the register.
  - Latency: the first bit is on q_o in the cycle after the accepting edge, with no tick needed.
  - On an edge with tick_i=1: shift the register by one toward the output end (zero fill) and increment the counter.
  - The edge with tick_i=1 and counter=Width-1 ends the word: go to IDLE and pulse done_o=1 for exactly one cycle, coincident with ready_o returning to 1.
  - No word may be accepted in that same cycle, so the minimum spacing between accepted words is Width ticks plus 1 cycle.
  - tick_i is ignored in IDLE.
- abort_i in SHIFT (or PARITY): next state is IDLE, no done_o, register and counter cleared. abort_i has priority over a simultaneous tick_i. abort_i in IDLE has no effect.
- Counter width is clog2(Width); the counter never wraps inside a word.
- Bit order is fixed for the whole word; a change on lsb_first_i mid-word is ignored.

Optional Feature:
- Macro: PISO_SERIALIZER_PARITY_EN.
- Defined:
  - Parity is computed at load as the XOR of d_i (even parity).
  - Instead of IDLE, the final data tick goes to PARITY, where q_o = the parity bit and q_valid_o=1.
  - The next tick_i goes to IDLE with the done_o pulse.
  - A word therefore takes Width+1 ticks.
- Undefined: PARITY state, parity logic and parity register are absent; a word takes Width ticks.

Decomposition:
- Shared package/include holds:
  - state encoding constants ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_PARITY=2'd2;
  - a clog2 constant function for the counter width.
- One natural sub-module: piso_bit_counter (Width-generic counter with clear, enable, and a terminal-count flag).
- FSM and shift register stay in the top module.

Test Plan:
- Reset: assert rst_i mid-word (after 3 ticks) -> next cycle ready_o=1, busy_o=0, q_o=IdleLevel, done_o never pulses.
- MSB first: Width=8, d_i=8'h96, lsb_first_i=0, tick_i=1 every cycle -> q_o sequence 1,0,0,1,0,1,1,0; done_o high exactly 1 cycle after the 8th tick.
- LSB first: d_i=8'h96, lsb_first_i=1, tick_i every 4th cycle -> q_o 0,1,1,0,1,0,0,1, each bit held 4 cycles; the first bit appears without a tick.
- Handshake: valid_i held high continuously with words 8'h01 then 8'hFF -> second word accepted only in the done_o cycle's following IDLE edge; no bit lost or duplicated.
- Abort: abort_i and tick_i asserted together on bit 5 -> IDLE next cycle, counter=0, no done_o, next word 8'hA0 serializes correctly.
- With PISO_SERIALIZER_PARITY_EN: d_i=8'h07 MSB first -> 8 data bits 0,0,0,0,0,1,1,1, then parity bit 1 on the 9th bit, done_o after the 9th tick.
